// File: rtl/rs_age.sv
// Age-ordered reservation station.
// Entries move EMPTY -> WAITING (allocate) -> ISSUED (issue handshake) -> EMPTY (free).
// An age matrix (older_q[j][i] = entry j was allocated before entry i) picks the
// oldest ready entry regardless of slot index, so ordering survives wrap-around.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high;
// once issue_valid is high and issue_ready is low, the offered entry is held until accepted.
// Optional feature: define RS_CDB_WAKEUP_BYPASS_EN to let a same-cycle CDB broadcast
// make a waiting entry an issue candidate combinationally.
module rs_age #(
    parameter int RS_DEPTH  = 8,
    parameter int N_CDB     = 2,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [PREG_W-1:0]         alloc_src1_tag,
    input  logic [PREG_W-1:0]         alloc_src2_tag,
    input  logic                      alloc_src1_rdy,
    input  logic                      alloc_src2_rdy,
    input  logic [PAYLOAD_W-1:0]      alloc_payload,
    input  logic [N_CDB-1:0]          cdb_valid,
    input  logic [N_CDB*PREG_W-1:0]   cdb_tag,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [PAYLOAD_W-1:0]      issue_payload,
    output logic [$clog2(RS_DEPTH)-1:0] issue_idx,
    input  logic                      free_valid,
    input  logic [$clog2(RS_DEPTH)-1:0] free_idx,
    output logic [$clog2(RS_DEPTH):0] count
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_WAITING, ST_ISSUED} entry_state_t;

    entry_state_t         state_q    [RS_DEPTH];
    logic [PREG_W-1:0]    src1_tag_q [RS_DEPTH];
    logic [PREG_W-1:0]    src2_tag_q [RS_DEPTH];
    logic [PAYLOAD_W-1:0] payload_q  [RS_DEPTH];
    logic [RS_DEPTH-1:0]  older_q    [RS_DEPTH];
    logic [RS_DEPTH-1:0]  src1_rdy_q;
    logic [RS_DEPTH-1:0]  src2_rdy_q;
    logic                 lock_valid_q;
    logic [IDX_W-1:0]     lock_idx_q;

    logic [RS_DEPTH-1:0]  wake1, wake2, cand;
    logic [CNT_W-1:0]     occ;
    logic [IDX_W-1:0]     alloc_idx, oldest_idx, sel_idx;
    logic                 alloc_found, any_cand, blocked;
    logic                 alloc_fire, issue_fire;
    logic                 new_src1_rdy, new_src2_rdy;

    // True when any valid CDB channel broadcasts the given tag.
    function automatic logic cdb_match(input logic [N_CDB-1:0] v,
                                       input logic [N_CDB*PREG_W-1:0] tags,
                                       input logic [PREG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < N_CDB; k++) begin
            if (v[k] && (tags[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Occupancy, wakeup matches, candidates, free-slot and oldest-candidate selection.
    always_comb begin
        occ         = '0;
        wake1       = '0;
        wake2       = '0;
        cand        = '0;
        alloc_idx   = '0;
        alloc_found = 1'b0;
        oldest_idx  = '0;
        any_cand    = 1'b0;
        blocked     = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (state_q[i] != ST_EMPTY) occ = occ + CNT_W'(1);
            if (state_q[i] == ST_EMPTY && !alloc_found) begin
                alloc_idx   = IDX_W'(i);
                alloc_found = 1'b1;
            end
            wake1[i] = cdb_match(cdb_valid, cdb_tag, src1_tag_q[i]);
            wake2[i] = cdb_match(cdb_valid, cdb_tag, src2_tag_q[i]);
`ifdef RS_CDB_WAKEUP_BYPASS_EN
            cand[i] = (state_q[i] == ST_WAITING) && (src1_rdy_q[i] || wake1[i])
                      && (src2_rdy_q[i] || wake2[i]);
`else
            cand[i] = (state_q[i] == ST_WAITING) && src1_rdy_q[i] && src2_rdy_q[i];
`endif
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cand[i]) begin
                blocked = 1'b0;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (cand[j] && older_q[j][i]) blocked = 1'b1;
                end
                if (!blocked) begin
                    oldest_idx = IDX_W'(i);
                    any_cand   = 1'b1;
                end
            end
        end
    end

    // Output selection: a stalled offer stays locked so payload/index do not move.
    always_comb begin
        sel_idx       = lock_valid_q ? lock_idx_q : oldest_idx;
        issue_valid   = lock_valid_q || any_cand;
        issue_idx     = issue_valid ? sel_idx : '0;
        issue_payload = issue_valid ? payload_q[sel_idx] : '0;
        count         = occ;
        alloc_ready   = (occ < CNT_W'(RS_DEPTH));
        alloc_fire    = alloc_valid && alloc_ready;
        issue_fire    = issue_valid && issue_ready;
        new_src1_rdy  = alloc_src1_rdy || (alloc_src1_tag == '0)
                        || cdb_match(cdb_valid, cdb_tag, alloc_src1_tag);
        new_src2_rdy  = alloc_src2_rdy || (alloc_src2_tag == '0)
                        || cdb_match(cdb_valid, cdb_tag, alloc_src2_tag);
    end

    // Entry state, wakeup, age matrix and issue lock; reset/flush override everything.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                state_q[i] <= ST_EMPTY;
                older_q[i] <= '0;
            end
            src1_rdy_q   <= '0;
            src2_rdy_q   <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (state_q[i] == ST_WAITING) begin
                    if (wake1[i]) src1_rdy_q[i] <= 1'b1;
                    if (wake2[i]) src2_rdy_q[i] <= 1'b1;
                end
                if (free_valid && (free_idx == IDX_W'(i)) && (state_q[i] == ST_ISSUED))
                    state_q[i] <= ST_EMPTY;
            end
            if (issue_fire) state_q[sel_idx] <= ST_ISSUED;
            if (alloc_fire) begin
                state_q[alloc_idx]    <= ST_WAITING;
                src1_tag_q[alloc_idx] <= alloc_src1_tag;
                src2_tag_q[alloc_idx] <= alloc_src2_tag;
                src1_rdy_q[alloc_idx] <= new_src1_rdy;
                src2_rdy_q[alloc_idx] <= new_src2_rdy;
                payload_q[alloc_idx]  <= alloc_payload;
                // The new entry is younger than every other slot.
                older_q[alloc_idx]    <= '0;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    if (IDX_W'(j) != alloc_idx) older_q[j][alloc_idx] <= 1'b1;
                end
            end
            lock_valid_q <= issue_valid && !issue_ready;
            lock_idx_q   <= sel_idx;
        end
    end
endmodule

// File: tb/tb_rs_age.sv
// Directed bench for rs_age with default parameters.
module tb_rs_age;
  localparam int D  = 8;
  localparam int NC = 2;
  localparam int PW = 6;
  localparam int LW = 64;
`ifdef RS_CDB_WAKEUP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, flush;
  logic          alloc_valid, alloc_ready;
  logic [PW-1:0] alloc_src1_tag, alloc_src2_tag;
  logic          alloc_src1_rdy, alloc_src2_rdy;
  logic [LW-1:0] alloc_payload;
  logic [NC-1:0] cdb_valid;
  logic [NC*PW-1:0] cdb_tag;
  logic          issue_valid, issue_ready;
  logic [LW-1:0] issue_payload;
  logic [2:0]    issue_idx;
  logic          free_valid;
  logic [2:0]    free_idx;
  logic [3:0]    count;

  int errors = 0;
  int checks = 0;
  logic [2:0]  exp_idx [8];
  logic [63:0] exp_pay [8];

  rs_age #(.RS_DEPTH(D), .N_CDB(NC), .PREG_W(PW), .PAYLOAD_W(LW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
    .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
    .alloc_payload(alloc_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_payload(issue_payload), .issue_idx(issue_idx),
    .free_valid(free_valid), .free_idx(free_idx), .count(count)
  );

  // clock / watchdog
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_src1_tag = '0; alloc_src2_tag = '0;
    alloc_src1_rdy = 0; alloc_src2_rdy = 0; alloc_payload = '0;
    cdb_valid = '0; cdb_tag = '0; issue_ready = 0; free_valid = 0; free_idx = '0;
  endtask

  task automatic alloc(input logic [PW-1:0] t1, input logic r1,
                       input logic [PW-1:0] t2, input logic r2, input logic [63:0] pay);
    alloc_valid = 1; alloc_src1_tag = t1; alloc_src1_rdy = r1;
    alloc_src2_tag = t2; alloc_src2_rdy = r2; alloc_payload = pay;
    tick();
    alloc_valid = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clock);
    tick();
    reset = 0;
    check("reset_count", 64'(count), 0);
    check("reset_alloc_ready", 64'(alloc_ready), 1);
    check("reset_issue_valid", 64'(issue_valid), 0);
    check("reset_issue_idx", 64'(issue_idx), 0);
    check("reset_issue_payload", issue_payload, 0);

    // fill with ready entries while downstream stalls
    for (int i = 0; i < 8; i++) alloc(6'd1, 1, 6'd2, 1, 64'h100 + 64'(i));
    check("full_count", 64'(count), 8);
    check("full_alloc_ready", 64'(alloc_ready), 0);
    check("full_issue_idx", 64'(issue_idx), 0);
    check("full_issue_payload", issue_payload, 64'h100);
    free_valid = 1; free_idx = 3'd5;
    tick();
    free_valid = 0;
    check("free_waiting_ignored", 64'(count), 8);
    check("stall_issue_idx", 64'(issue_idx), 0);

    // issue entries 0,1,2
    issue_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check("issue_first3_idx", 64'(issue_idx), 64'(i));
      tick();
    end
    issue_ready = 0;
    check("after3_count", 64'(count), 8);

    // same-cycle free of entry 2 and alloc: alloc refused
    free_valid = 1; free_idx = 3'd2;
    alloc_valid = 1; alloc_src1_tag = 0; alloc_src2_tag = 0; alloc_payload = 64'h300;
    check("free_alloc_ready", 64'(alloc_ready), 0);
    tick();
    free_valid = 0;
    check("free_alloc_count", 64'(count), 7);
    check("free_alloc_ready_next", 64'(alloc_ready), 1);
    tick();
    alloc_valid = 0;
    check("realloc2_count", 64'(count), 8);

    // free 0 and 1, reallocate them as youngest
    free_valid = 1; free_idx = 3'd0;
    tick();
    free_valid = 0;
    check("free0_count", 64'(count), 7);
    alloc(0, 1, 0, 1, 64'h400);
    free_valid = 1; free_idx = 3'd1;
    tick();
    free_valid = 0;
    alloc(0, 1, 0, 1, 64'h401);
    check("realloc01_count", 64'(count), 8);

    exp_idx = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd0, 3'd1};
    exp_pay = '{64'h103, 64'h104, 64'h105, 64'h106, 64'h107, 64'h300, 64'h400, 64'h401};
    issue_ready = 1;
    for (int k = 0; k < 7; k++) begin
      check("age_order_idx", 64'(issue_idx), 64'(exp_idx[k]));
      check("age_order_payload", issue_payload, exp_pay[k]);
      if (k < 6) tick();
    end
    // flush with a live candidate and issue_ready high
    do_flush();
    issue_ready = 0;
    check("flush_count", 64'(count), 0);
    check("flush_issue_valid", 64'(issue_valid), 0);
    check("flush_alloc_ready", 64'(alloc_ready), 1);

    // A waits on tag 5, B ready: B first, then A
    alloc(6'd5, 0, 0, 0, 64'hAA);
    check("a_not_ready", 64'(issue_valid), 0);
    alloc(0, 1, 0, 1, 64'hBB);
    check("b_offered_idx", 64'(issue_idx), 1);
    check("b_offered_payload", issue_payload, 64'hBB);
    tick();
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd5};
    check("b_stable_during_cdb", 64'(issue_idx), 1);
    tick();
    cdb_valid = '0;
    check("b_stable_after_cdb", 64'(issue_idx), 1);
    issue_ready = 1;
    tick();
    check("a_second_idx", 64'(issue_idx), 0);
    check("a_second_payload", issue_payload, 64'hAA);
    tick();
    issue_ready = 0;
    check("ab_drained", 64'(issue_valid), 0);

    // allocation-cycle capture on CDB channel 1
    do_flush();
    cdb_valid = 2'b10; cdb_tag = {6'd9, 6'd0};
    alloc(6'd9, 0, 0, 0, 64'hCC);
    cdb_valid = '0;
    check("alloc_capture_valid", 64'(issue_valid), 1);
    check("alloc_capture_payload", issue_payload, 64'hCC);

    // wakeup bypass timing
    do_flush();
    alloc(6'd3, 0, 0, 1, 64'hDD);
    check("bypass_pre", 64'(issue_valid), 0);
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd3};
    check("bypass_same_cycle", 64'(issue_valid), 64'(BYP));
    tick();
    cdb_valid = '0;
    check("bypass_next_cycle", 64'(issue_valid), 1);

    // two pending sources, a non-matching tag must not wake
    do_flush();
    alloc(6'd7, 0, 6'd8, 0, 64'hEE);
    cdb_valid = 2'b10; cdb_tag = {6'd7, 6'd0};
    tick();
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd9};
    check("wrong_tag_no_wake", 64'(issue_valid), 0);
    tick();
    cdb_valid = 2'b10; cdb_tag = {6'd8, 6'd0};
    check("last_src_bypass", 64'(issue_valid), 64'(BYP));
    tick();
    cdb_valid = '0;
    check("last_src_woken", 64'(issue_valid), 1);
    check("last_src_payload", issue_payload, 64'hEE);

    // reset mid-operation with a same-cycle free
    issue_ready = 1;
    tick();
    issue_ready = 0;
    reset = 1; free_valid = 1; free_idx = 3'd0;
    tick();
    reset = 0; free_valid = 0;
    check("midreset_count", 64'(count), 0);
    check("midreset_issue_valid", 64'(issue_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
